muldiv_seq: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs an iterative 32-step shift-add or restoring-divide engine. It raises stall_req toward the hazard/stall logic while a HI/LO consumer or a new md op would collide with an operation in flight.

---
 rtl/muldiv_seq_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_seq.sv | 118 +++++++++++
 tb/tb_muldiv_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - opcode encodings, FSM states and opcode decode helpers for muldiv_seq
package muldiv_seq_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } md_state_e;

    function automatic logic is_engine_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add multiply or restoring-divide iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Multiply keeps {acc,q} as the 2*WIDTH product shifting right; divide shifts
    // {acc,q} left and builds the quotient in q from the restore decision.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, {WIDTH{q[0]}} & d};
        shifted  = {acc, q[WIDTH-1]};
        fits     = shifted >= {1'b0, d};
        diff     = shifted[WIDTH-1:0] - d;
        acc_next = sum[WIDTH:1];
        q_next   = {sum[0], q[WIDTH-1:1]};
        if (is_div) begin
            acc_next = fits ? diff : shifted[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative multiply/divide sequencer owning the HI/LO pair
module muldiv_seq #(
    parameter int WIDTH     = 32,
    parameter bit ZERO_SKIP = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_hilo,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);
    import muldiv_seq_pkg::*;

    localparam int CW = $clog2(WIDTH);

    md_state_e          state, state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc, q, dv, acc_step, q_step;
    logic               op_div, neg_q, neg_r, div_zero;
    logic               accept, engine_go, skip, sa, sb;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    assign accept    = (state == ST_IDLE) && start && !flush;
    assign engine_go = accept && is_engine_op(md_op);
    assign skip      = ZERO_SKIP && !is_div_op(md_op) && ((op_a == '0) || (op_b == '0));
    assign sa        = is_signed_op(md_op) && op_a[WIDTH-1];
    assign sb        = is_signed_op(md_op) && op_b[WIDTH-1];

    assign busy      = (state != ST_IDLE);
    assign stall_req = busy && (start || rd_hilo);
    assign done      = (state == ST_FIXUP) && !flush;

    assign prod_fix  = neg_q ? -{acc, q} : {acc, q};
    assign quo       = cond_neg(q, neg_q);
    assign rem       = cond_neg(acc, neg_r);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_div),
        .acc      (acc),
        .q        (q),
        .d        (dv),
        .acc_next (acc_step),
        .q_next   (q_step)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (engine_go) state_next = skip ? ST_FIXUP : ST_CALC;
            ST_CALC:  if (flush) state_next = ST_IDLE;
                      else if (count == '0) state_next = ST_FIXUP;
            ST_FIXUP: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            q        <= '0;
            dv       <= '0;
            count    <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            if (accept && md_op == MD_MTHI) hi <= op_a;
            if (accept && md_op == MD_MTLO) lo <= op_a;
            if (engine_go) begin
                // Zeroing q on a skipped multiply makes the FIXUP product zero directly.
                acc      <= '0;
                q        <= skip ? '0 : cond_neg(op_a, sa);
                dv       <= cond_neg(op_b, sb);
                count    <= CW'(WIDTH - 1);
                op_div   <= is_div_op(md_op);
                neg_q    <= sa ^ sb;
                neg_r    <= sa;
                div_zero <= (op_b == '0);
            end else if (state == ST_CALC) begin
                acc   <= acc_step;
                q     <= q_step;
                count <= count - CW'(1);
            end
            // Divide by zero leaves |a| in acc, so the sign-restored remainder is op_a itself.
            if (state == ST_FIXUP && !flush) begin
                if (op_div) begin
                    hi <= rem;
                    lo <= div_zero ? {WIDTH{1'b1}} : quo;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed bench with a HI/LO result scoreboard for muldiv_seq
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rstn, start, rd_hilo, flush;
    logic [2:0]  md_op;
    logic [31:0] op_a, op_b;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          passes = 0;
    int          pushes = 0;
    int          done_count = 0;
    int          lat;
    logic [63:0] sb_q[$];
    logic [63:0] last_exp = 64'h0;
    logic        sb_pending = 1'b0;

    muldiv_seq #(.WIDTH(32), .ZERO_SKIP(1)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .md_op     (md_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_hilo   (rd_hilo),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (sb_pending) begin
            if (sb_q.size() == 0) check("sb_unexpected_done", 64'(sb_q.size()), 64'd1);
            else check("sb_hilo", {hi, lo}, sb_q.pop_front());
        end
        sb_pending = (done === 1'b1);
        if (done === 1'b1) done_count++;
    end

    // Drives one start cycle; returns at posedge+4 of the cycle after acceptance.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] exp);
        @(posedge clk); #1;
        start = 1'b1; md_op = op; op_a = a; op_b = b;
        if (push) begin
            sb_q.push_back(exp);
            pushes++;
            last_exp = exp;
        end
        @(posedge clk); #1;
        start = 1'b0;
        #3;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #4;
            cyc++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic signed [63:0] sp;

        rstn = 1'b0; start = 1'b1; rd_hilo = 1'b1; flush = 1'b0;
        md_op = MD_MULT; op_a = 32'd5; op_b = 32'd7;
        repeat (3) @(posedge clk);
        #4;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'h0);
        @(posedge clk); #1;
        rstn = 1'b1; start = 1'b0; rd_hilo = 1'b0;

        issue(MD_MULT, 32'hFFFFFFFD, 32'd7, 1, 64'hFFFFFFFF_FFFFFFEB);
        check("mult_busy_n1", 64'(busy), 64'd1);
        wait_done(lat);
        check("mult_latency", 64'(lat), 64'd33);
        check("mult_busy_n33", 64'(busy), 64'd1);
        @(posedge clk); #4;
        check("mult_busy_n34", 64'(busy), 64'd0);
        check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

        issue(MD_DIVU, 32'd100, 32'd7, 1, {32'd2, 32'd14});
        rd_hilo = 1'b1;
        #1;
        check("mflo_stall", 64'(stall_req), 64'd1);
        wait_done(lat);
        check("mflo_stall_fixup", 64'(stall_req), 64'd1);
        check("divu_latency", 64'(lat), 64'd33);
        @(posedge clk); #4;
        check("mflo_stall_idle", 64'(stall_req), 64'd0);
        check("divu_hilo", {hi, lo}, {32'd2, 32'd14});
        rd_hilo = 1'b0;

        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1, 64'hFFFFFFFF_FFFFFFFD);
        wait_done(lat);
        check("div_neg_latency", 64'(lat), 64'd33);
        issue(MD_DIV, 32'd5, 32'd0, 1, {32'd5, 32'hFFFFFFFF});
        wait_done(lat);
        issue(MD_DIV, 32'hFFFFFFFB, 32'd0, 1, {32'hFFFFFFFB, 32'hFFFFFFFF});
        wait_done(lat);
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1, {32'd0, 32'h80000000});
        wait_done(lat);
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'hFFFFFFFE_00000001);
        wait_done(lat);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 1) begin
                rb = rb >> $urandom_range(0, 28);
                if (rb == 32'd0) rb = 32'd3;
                issue(MD_DIVU, ra, rb, 1, {ra % rb, ra / rb});
            end else begin
                if (ra == 32'd0) ra = 32'd9;
                if (rb == 32'd0) rb = 32'd11;
                sp = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
                issue(MD_MULT, ra, rb, 1, sp);
            end
            wait_done(lat);
            check("rand_latency", 64'(lat), 64'd33);
        end

        issue(MD_MULT, 32'd6, 32'd7, 0, 64'h0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        #3;
        check("flush_busy_n10", 64'(busy), 64'd1);
        check("flush_no_done", 64'(done), 64'd0);
        @(posedge clk); #1 flush = 1'b0;
        #3;
        check("flush_busy_n11", 64'(busy), 64'd0);
        check("flush_hilo_kept", {hi, lo}, last_exp);
        repeat (40) @(posedge clk);
        #4;
        check("flush_done_count", 64'(done_count), 64'(pushes));

        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; md_op = MD_MTHI; op_a = 32'hDEAD0000;
        @(posedge clk); #1;
        md_op = MD_MULT; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        #3;
        check("idle_flush_busy", 64'(busy), 64'd0);
        check("idle_flush_hilo", {hi, lo}, last_exp);

        @(posedge clk); #1;
        start = 1'b1; md_op = MD_MTHI; op_a = 32'h1234; rd_hilo = 1'b1;
        #3;
        check("mthi_stall", 64'(stall_req), 64'd0);
        check("mthi_same_cycle_hi", 64'(hi), 64'(last_exp[63:32]));
        @(posedge clk); #1;
        md_op = MD_MTLO; op_a = 32'hABCD;
        #3;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mtlo_same_cycle_lo", 64'(lo), 64'(last_exp[31:0]));
        @(posedge clk); #1;
        start = 1'b0; rd_hilo = 1'b0;
        #3;
        check("mtlo_hilo", {hi, lo}, {32'h1234, 32'hABCD});

        issue(MD_MULT, 32'd3, 32'd5, 1, 64'd15);
        start = 1'b1; md_op = MD_MULT; op_a = 32'd2; op_b = 32'd9;
        sb_q.push_back(64'd18);
        pushes++;
        #1;
        check("busy_start_stall", 64'(stall_req), 64'd1);
        wait_done(lat);
        check("first_latency", 64'(lat), 64'd33);
        check("fixup_start_stall", 64'(stall_req), 64'd1);
        @(posedge clk); #4;
        check("held_start_stall", 64'(stall_req), 64'd0);
        check("held_start_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        #3;
        check("held_start_accepted", 64'(busy), 64'd1);
        wait_done(lat);
        check("second_latency", 64'(lat), 64'd33);

        issue(MD_MULT, 32'h1234, 32'h5678, 0, 64'h0);
        repeat (15) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hilo", {hi, lo}, 64'h0);
        @(posedge clk); #1 rstn = 1'b1;

        issue(MD_MTHI, 32'h1111, 32'h0, 0, 64'h0);
        issue(MD_MTLO, 32'h2222, 32'h0, 0, 64'h0);
        check("pre_skip_hilo", {hi, lo}, {32'h1111, 32'h2222});
        issue(MD_MULTU, 32'h55, 32'd0, 1, 64'h0);
        wait_done(lat);
        check("skip_latency", 64'(lat), 64'd1);
        @(posedge clk); #4;
        check("skip_busy", 64'(busy), 64'd0);
        check("skip_hilo", {hi, lo}, 64'h0);
        issue(MD_MULT, 32'd0, 32'hFFFFFFFB, 1, 64'h0);
        wait_done(lat);
        check("skip_signed_latency", 64'(lat), 64'd1);

        repeat (3) @(posedge clk);
        #4;
        check("final_done_count", 64'(done_count), 64'(pushes));
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
